// File: rtl/sccb_cfg_seq.sv
// sccb_cfg_seq: table-driven SCCB/I2C register configuration sequencer.
// Walks an external register table (synchronous ROM, 1-cycle latency),
// handing each address/data pair to an I2C master through an exec/done
// handshake. Supports inline delay entries, NACK retry and a failure
// report; init_done gates the downstream capture path.
//
// Optional build macro: CFG_READBACK_EN
//   When defined, every successful write of an entry with nv_flag = 0 is
//   followed by a read of the same register. A read NACK or a data
//   mismatch counts as one failed attempt, and the retry restarts from
//   the write. When undefined, nv_flag is ignored and i2c_rh_wl is tied 0.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   tbl_addr     table read address (= current entry index)
//   tbl_data     {dly_flag, nv_flag, reg_addr[ADDR_W-1:0], reg_data[7:0]}
//   i2c_exec     single-cycle transfer request
//   i2c_rh_wl    1 = read, 0 = write
//   i2c_addr     register address, held until i2c_done
//   i2c_data     write data, held until i2c_done
//   i2c_done     single-cycle completion pulse from the master
//   i2c_ack_err  NACK flag, valid with i2c_done
//   i2c_rdata    read data, valid with i2c_done
//   cfg_start    re-run pulse, honoured only in DONE or FAIL
//   busy         high while the sequence is in progress
//   init_done    whole table completed without error
//   cfg_err      an entry exhausted its attempts
//   err_idx      index of the failing entry
module sccb_cfg_seq #(
  parameter int unsigned POWERUP_DLY = 20000,
  parameter int unsigned REG_NUM     = 201,
  parameter int unsigned TBL_AW      = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DLY_UNIT    = 1000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [ADDR_W+9:0] tbl_data,
  output logic              i2c_exec,
  output logic              i2c_rh_wl,
  output logic [ADDR_W-1:0] i2c_addr,
  output logic [7:0]        i2c_data,
  input  logic              i2c_done,
  input  logic              i2c_ack_err,
  input  logic [7:0]        i2c_rdata,
  input  logic              cfg_start,
  output logic              busy,
  output logic              init_done,
  output logic              cfg_err,
  output logic [TBL_AW-1:0] err_idx
);

  localparam int unsigned PWR_LAST = (POWERUP_DLY > 0) ? POWERUP_DLY - 1 : 0;
  localparam int unsigned DLY_MAX  = 255 * DLY_UNIT;
  localparam int unsigned PW_W     = (PWR_LAST > 0) ? $clog2(PWR_LAST + 1) : 1;
  localparam int unsigned DW       = (DLY_MAX > 0) ? $clog2(DLY_MAX + 1) : 1;
  localparam int unsigned CNT_W    = (PW_W > DW) ? PW_W : DW;
  localparam int unsigned RC_W     = $clog2(MAX_RETRY + 1);
  localparam int unsigned LAST_IDX = REG_NUM - 1;

  typedef enum logic [3:0] {
    S_PWRUP,
    S_FETCH,
    S_FLATCH,
    S_DELAY,
    S_ISSUE,
    S_WAIT,
`ifdef CFG_READBACK_EN
    S_RD_ISSUE,
    S_RD_WAIT,
`endif
    S_DONE,
    S_FAIL
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TBL_AW-1:0] idx_q, idx_d;
  logic [RC_W-1:0]   retry_q, retry_d;
  logic [TBL_AW-1:0] tbl_addr_q, tbl_addr_d;
  logic              i2c_exec_q, i2c_exec_d;
  logic [ADDR_W-1:0] i2c_addr_q, i2c_addr_d;
  logic [7:0]        i2c_data_q, i2c_data_d;
  logic              busy_q, busy_d;
  logic              init_done_q, init_done_d;
  logic              cfg_err_q, cfg_err_d;
  logic [TBL_AW-1:0] err_idx_q, err_idx_d;
  logic              adv_c;
  logic              fail_c;

  // Entry fields straight off the ROM output (valid in FLATCH)
  logic              ent_dly_c;
  logic [ADDR_W-1:0] ent_addr_c;
  logic [7:0]        ent_data_c;
  logic [CNT_W-1:0]  dly_cycles_c;

  assign ent_dly_c    = tbl_data[ADDR_W+9];
  assign ent_addr_c   = tbl_data[ADDR_W+7:8];
  assign ent_data_c   = tbl_data[7:0];
  assign dly_cycles_c = CNT_W'(ent_data_c) * CNT_W'(DLY_UNIT);

`ifdef CFG_READBACK_EN
  logic ent_nv_q, ent_nv_d;
  logic i2c_rh_wl_q, i2c_rh_wl_d;
`else
  logic unused_c;
  assign unused_c = ^{i2c_rdata, tbl_data[ADDR_W+8]};
`endif

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    retry_d     = retry_q;
    i2c_addr_d  = i2c_addr_q;
    i2c_data_d  = i2c_data_q;
    err_idx_d   = err_idx_q;
    init_done_d = init_done_q;
    cfg_err_d   = cfg_err_q;
    adv_c       = 1'b0;
    fail_c      = 1'b0;
`ifdef CFG_READBACK_EN
    ent_nv_d    = ent_nv_q;
`endif

    case (state_q)
      S_PWRUP: begin
        if (cnt_q == CNT_W'(PWR_LAST)) begin
          cnt_d   = '0;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // tbl_addr already equals idx; the ROM answers next cycle
      S_FETCH: state_d = S_FLATCH;

      S_FLATCH: begin
        if (ent_dly_c) begin
          cnt_d   = dly_cycles_c;
          state_d = S_DELAY;
        end else begin
          i2c_addr_d = ent_addr_c;
          i2c_data_d = ent_data_c;
`ifdef CFG_READBACK_EN
          ent_nv_d   = tbl_data[ADDR_W+8];
`endif
          state_d    = S_ISSUE;
        end
      end

      // Down-count; a zero or one-cycle delay still spends one cycle here
      S_DELAY: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d = '0;
          adv_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_ISSUE: state_d = S_WAIT;

      S_WAIT: begin
        if (i2c_done) begin
          if (i2c_ack_err) begin
            fail_c = 1'b1;
          end else begin
`ifdef CFG_READBACK_EN
            if (ent_nv_q) adv_c = 1'b1;
            else          state_d = S_RD_ISSUE;
`else
            adv_c = 1'b1;
`endif
          end
        end
      end

`ifdef CFG_READBACK_EN
      S_RD_ISSUE: state_d = S_RD_WAIT;

      S_RD_WAIT: begin
        if (i2c_done) begin
          if (i2c_ack_err || (i2c_rdata != i2c_data_q)) fail_c = 1'b1;
          else                                          adv_c  = 1'b1;
        end
      end
`endif

      S_DONE, S_FAIL: begin
        if (cfg_start) begin
          idx_d       = '0;
          retry_d     = '0;
          init_done_d = 1'b0;
          cfg_err_d   = 1'b0;
          state_d     = S_FETCH;
        end
      end

      default: state_d = S_PWRUP;
    endcase

    // Entry finished: move on or close the table (idx never wraps)
    if (adv_c) begin
      retry_d = '0;
      if (idx_q == TBL_AW'(LAST_IDX)) begin
        init_done_d = 1'b1;
        state_d     = S_DONE;
      end else begin
        idx_d   = idx_q + TBL_AW'(1);
        state_d = S_FETCH;
      end
    end

    // Failed attempt: retry from the write, or give up on the last one
    if (fail_c) begin
      retry_d = retry_q + RC_W'(1);
      if (retry_q == RC_W'(MAX_RETRY - 1)) begin
        cfg_err_d = 1'b1;
        err_idx_d = idx_q;
        state_d   = S_FAIL;
      end else begin
        state_d = S_ISSUE;
      end
    end

    tbl_addr_d = idx_d;
    busy_d     = !((state_d == S_DONE) || (state_d == S_FAIL));
`ifdef CFG_READBACK_EN
    i2c_exec_d  = (state_d == S_ISSUE) || (state_d == S_RD_ISSUE);
    i2c_rh_wl_d = i2c_rh_wl_q;
    if (state_d == S_RD_ISSUE) i2c_rh_wl_d = 1'b1;
    else if (state_d == S_ISSUE) i2c_rh_wl_d = 1'b0;
`else
    i2c_exec_d  = (state_d == S_ISSUE);
`endif
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_PWRUP;
      cnt_q       <= '0;
      idx_q       <= '0;
      retry_q     <= '0;
      tbl_addr_q  <= '0;
      i2c_exec_q  <= 1'b0;
      i2c_addr_q  <= '0;
      i2c_data_q  <= '0;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      err_idx_q   <= '0;
`ifdef CFG_READBACK_EN
      ent_nv_q    <= 1'b0;
      i2c_rh_wl_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      tbl_addr_q  <= tbl_addr_d;
      i2c_exec_q  <= i2c_exec_d;
      i2c_addr_q  <= i2c_addr_d;
      i2c_data_q  <= i2c_data_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
      cfg_err_q   <= cfg_err_d;
      err_idx_q   <= err_idx_d;
`ifdef CFG_READBACK_EN
      ent_nv_q    <= ent_nv_d;
      i2c_rh_wl_q <= i2c_rh_wl_d;
`endif
    end
  end

  assign tbl_addr  = tbl_addr_q;
  assign i2c_exec  = i2c_exec_q;
  assign i2c_addr  = i2c_addr_q;
  assign i2c_data  = i2c_data_q;
  assign busy      = busy_q;
  assign init_done = init_done_q;
  assign cfg_err   = cfg_err_q;
  assign err_idx   = err_idx_q;
`ifdef CFG_READBACK_EN
  assign i2c_rh_wl = i2c_rh_wl_q;
`else
  assign i2c_rh_wl = 1'b0;
`endif

endmodule

// File: tb/tb_sccb_cfg_seq.sv
// Bench for sccb_cfg_seq: random tables and NACK plans; a transaction-level
// model predicts the cycle, direction, address and data of every exec pulse
// and the final init_done / cfg_err outcome.
// Cycle convention: cyc counts rising edges; outputs are sampled on the
// falling edge, and an input driven at falling edge c is seen at edge c+1.
module tb_sccb_cfg_seq;

  localparam int unsigned P_PWR   = 16;
  localparam int unsigned P_REG   = 6;
  localparam int unsigned P_AW    = 3;
  localparam int unsigned P_AD    = 16;
  localparam int unsigned P_UNIT  = 10;
  localparam int unsigned P_RETRY = 3;
  localparam int unsigned EW      = P_AD + 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [P_AW-1:0] tbl_addr;
  logic [EW-1:0]   tbl_data = '0;
  logic            i2c_exec;
  logic            i2c_rh_wl;
  logic [P_AD-1:0] i2c_addr;
  logic [7:0]      i2c_data;
  logic            i2c_done = 1'b0;
  logic            i2c_ack_err = 1'b0;
  logic [7:0]      i2c_rdata = '0;
  logic            cfg_start = 1'b0;
  logic            busy;
  logic            init_done;
  logic            cfg_err;
  logic [P_AW-1:0] err_idx;

  sccb_cfg_seq #(
    .POWERUP_DLY(P_PWR), .REG_NUM(P_REG), .TBL_AW(P_AW),
    .ADDR_W(P_AD), .DLY_UNIT(P_UNIT), .MAX_RETRY(P_RETRY)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .i2c_exec(i2c_exec), .i2c_rh_wl(i2c_rh_wl), .i2c_addr(i2c_addr),
    .i2c_data(i2c_data), .i2c_done(i2c_done), .i2c_ack_err(i2c_ack_err),
    .i2c_rdata(i2c_rdata), .cfg_start(cfg_start), .busy(busy),
    .init_done(init_done), .cfg_err(cfg_err), .err_idx(err_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous table ROM with one cycle of latency
  logic [EW-1:0] rom [0:(1<<P_AW)-1];
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  int checks = 0;
  int errors = 0;
  int fails [P_REG];   // failed attempts planned per entry (>= P_RETRY aborts)
`ifdef CFG_READBACK_EN
  bit mm_first [P_REG]; // first failure of the entry is a readback mismatch
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input bit dly, input bit nv,
                                       input logic [P_AD-1:0] a, input logic [7:0] d);
    return {dly, nv, a, d};
  endfunction

  task automatic goto_cyc(input int c);
    int n = 0;
    while (cyc < c && n < 20000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic expect_exec(input string tag, input int texp, input bit rw,
                             input logic [P_AD-1:0] a, input logic [7:0] d);
    int seen = -1;
    while (cyc <= texp + 8) begin
      if (i2c_exec === 1'b1) begin
        seen = cyc;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_cycle"}, 32'(seen), 32'(texp));
    chk({tag, "_rh_wl"}, 32'(i2c_rh_wl), 32'(rw));
    chk({tag, "_addr"}, 32'(i2c_addr), 32'(a));
    chk({tag, "_data"}, 32'(i2c_data), 32'(d));
  endtask

  // I2C master stand-in: random latency, then a one-cycle done pulse
  task automatic respond(input bit nack, input logic [7:0] rd,
                         input logic [P_AD-1:0] a, output int dcyc);
    int lat = int'($urandom_range(1, 4));
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      if (k == 0) chk("exec_single", 32'(i2c_exec), 32'd0);
    end
    chk("addr_hold", 32'(i2c_addr), 32'(a));
    i2c_done    = 1'b1;
    i2c_ack_err = nack;
    i2c_rdata   = rd;
    dcyc        = cyc;
    @(negedge clk);
    i2c_done    = 1'b0;
    i2c_ack_err = 1'b0;
    i2c_rdata   = 8'($urandom);
  endtask

  task automatic pulse_start(output int s);
    cfg_start = 1'b1;
    s = cyc;
    @(negedge clk);
    cfg_start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_init_clr", 32'(init_done), 32'd0);
    chk("start_err_clr", 32'(cfg_err), 32'd0);
  endtask

  function automatic logic [EW-1:0] rand_entry();
    if ($urandom_range(0, 3) == 0)
      return mk(1'b1, 1'($urandom), 16'($urandom), 8'($urandom_range(0, 4)));
    return mk(1'b0, 1'($urandom), 16'($urandom), 8'($urandom));
  endfunction

  task automatic rand_plan(input bit may_fail);
    for (int i = 0; i < P_REG; i++) begin
      rom[i] = rand_entry();
      fails[i] = int'($urandom_range(0, P_RETRY - 1));
      if (may_fail && $urandom_range(0, 7) == 0) fails[i] = P_RETRY;
`ifdef CFG_READBACK_EN
      mm_first[i] = 1'($urandom);
`endif
    end
  endtask

  // Reference model: t is the cycle in which the DUT fetches the next entry.
  // Write entry: exec 2 cycles after fetch; after a NACK, exec the cycle after
  // done; delay entry: fetch + latch + max(1, n*DLY_UNIT) cycles.
  task automatic run_table(input int t0);
    int t, texp, nf, d, dcyc, kind;
    bit fail_now, dly, nv, fin;
    logic [P_AD-1:0] a;
    logic [7:0] dt;
    logic [EW-1:0] e;
    t = t0;
    for (int i = 0; i < P_REG; i++) begin
      e   = rom[i];
      dly = e[EW-1];
      nv  = e[EW-2];
      a   = e[EW-3:8];
      dt  = e[7:0];
      if (dly) begin
        d = int'(dt) * int'(P_UNIT);
        if (d == 0) d = 1;
        t = t + 2 + d;
        continue;
      end
      texp = t + 2;
      nf   = 0;
      fin  = 1'b0;
      while (!fin) begin
        expect_exec("wr", texp, 1'b0, a, dt);
        fail_now = (nf < fails[i]);
        kind = 0;
`ifdef CFG_READBACK_EN
        if (fail_now && !nv)
          kind = (mm_first[i] && nf == 0) ? 2 : int'($urandom_range(0, 2));
`endif
        respond(fail_now && kind == 0, 8'($urandom), a, dcyc);
`ifdef CFG_READBACK_EN
        if (!(fail_now && kind == 0) && !nv) begin
          expect_exec("rd", dcyc + 1, 1'b1, a, dt);
          respond(fail_now && kind == 1, (fail_now && kind == 2) ? (dt ^ 8'h04) : dt, a, dcyc);
        end
`else
        if (nv) kind = 0;
`endif
        if (fail_now) begin
          nf++;
          if (nf == P_RETRY) begin
            chk("fail_cfg_err", 32'(cfg_err), 32'd1);
            chk("fail_err_idx", 32'(err_idx), 32'(i));
            chk("fail_init_done", 32'(init_done), 32'd0);
            chk("fail_busy", 32'(busy), 32'd0);
            return;
          end
          texp = dcyc + 1;
        end else begin
          t   = dcyc + 1;
          fin = 1'b1;
        end
      end
    end
    if (cyc < t) begin
      goto_cyc(t - 1);
      chk("pre_done_busy", 32'(busy), 32'd1);
      chk("pre_done_init", 32'(init_done), 32'd0);
    end
    goto_cyc(t);
    chk("done_init", 32'(init_done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_cfg_err", 32'(cfg_err), 32'd0);
  endtask

  initial begin
    int r, s;
    for (int i = 0; i < (1 << P_AW); i++) rom[i] = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_exec", 32'(i2c_exec), 32'd0);
    chk("rst_tbl_addr", 32'(tbl_addr), 32'd0);
    chk("rst_err_idx", 32'(err_idx), 32'd0);
    chk("rst_i2c_addr", 32'(i2c_addr), 32'd0);

    // Run 1: directed table, 16-bit address, 50-cycle delay, NACK retries
    rom[0] = mk(1'b0, 1'b0, 16'h3008, 8'h82);
    rom[1] = mk(1'b0, 1'b0, 16'h3103, 8'h11);
    rom[2] = mk(1'b1, 1'b0, 16'h0000, 8'd5);
    rom[3] = mk(1'b0, 1'b0, 16'h0011, 8'h00);
    rom[4] = mk(1'b0, 1'b1, 16'h3012, 8'h80);
    rom[5] = mk(1'b0, 1'b0, 16'h4300, 8'h6f);
    for (int i = 0; i < P_REG; i++) fails[i] = 0;
    fails[1] = 2;
    fails[3] = 1;
`ifdef CFG_READBACK_EN
    for (int i = 0; i < P_REG; i++) mm_first[i] = 1'b0;
    mm_first[3] = 1'b1;
`endif
    rst_n = 1'b1;
    r = cyc;
    // Stray done and cfg_start during power-up must change nothing
    goto_cyc(r + 3);
    i2c_done = 1'b1; i2c_ack_err = 1'b1; cfg_start = 1'b1;
    @(negedge clk);
    i2c_done = 1'b0; i2c_ack_err = 1'b0; cfg_start = 1'b0;
    chk("pwrup_busy", 32'(busy), 32'd1);
    run_table(r + P_PWR);

    // Run 2: entry 2 NACKs on every attempt -> FAIL with err_idx 2
    rand_plan(1'b0);
    rom[2] = mk(1'b0, 1'($urandom), 16'($urandom), 8'($urandom));
    fails[2] = P_RETRY;
    pulse_start(s);
    run_table(s + 1);
    goto_cyc(cyc + 12);
    chk("fail_hold_exec", 32'(i2c_exec), 32'd0);
    chk("fail_hold_err", 32'(cfg_err), 32'd1);

    // Run 3: rerun from FAIL, last entry a zero-length delay
    rand_plan(1'b0);
    rom[P_REG-1] = mk(1'b1, 1'b0, 16'h0, 8'd0);
    pulse_start(s);
    run_table(s + 1);

    // Random runs, occasionally ending in FAIL
    for (int n = 0; n < 5; n++) begin
      rand_plan(1'b1);
      pulse_start(s);
      run_table(s + 1);
    end

    // Reset in the middle of a transfer, then a full run from power-up
    rand_plan(1'b0);
    rom[0] = mk(1'b0, 1'b0, 16'h1234, 8'h5a);
    pulse_start(s);
    expect_exec("pre_rst", s + 3, 1'b0, 16'h1234, 8'h5a);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_exec", 32'(i2c_exec), 32'd0);
    chk("mid_rst_init", 32'(init_done), 32'd0);
    @(negedge clk);
    for (int i = 0; i < P_REG; i++) fails[i] = 0;
    rst_n = 1'b1;
    r = cyc;
    run_table(r + P_PWR);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sccb_cfg_seq.md
Name: sccb_cfg_seq

Overview:
Table-driven SCCB/I2C register configuration sequencer for CMOS sensors (OV2640/OV5640 class). It walks an external register table entry by entry and hands each address/data pair to the existing I2C master through an exec/done handshake. It supports 8- or 16-bit register addresses, inline delay entries and NACK retry. It sits between the sensor table ROM and the I2C master, and gates the capture path through init_done.

Parameters:
POWERUP_DLY, 20000, cycles to wait after reset before the first transfer (20 ms at 1 MHz).
REG_NUM, 201, number of table entries (1..2^TBL_AW).
TBL_AW, 8, table address width.
ADDR_W, 8, sensor register address width; legal values are 8 or 16.
DLY_UNIT, 1000, clk cycles per delay-entry tick (1 ms at 1 MHz).
MAX_RETRY, 3, attempts per entry before failure (minimum 1).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
tbl_addr  out  TBL_AW  table read address
tbl_data  in  ADDR_W+10  {dly_flag, nv_flag, reg_addr[ADDR_W-1:0], reg_data[7:0]}, synchronous ROM, 1-cycle latency
i2c_exec  out  1  single-cycle transfer request
i2c_rh_wl  out  1  1 = read, 0 = write
i2c_addr  out  ADDR_W  register address
i2c_data  out  8  write data
i2c_done  in  1  single-cycle completion pulse
i2c_ack_err  in  1  NACK flag, valid with i2c_done
i2c_rdata  in  8  read data, valid with i2c_done
cfg_start  in  1  re-run pulse; honoured only in DONE or FAIL
busy  out  1  high in any state other than DONE and FAIL
init_done  out  1  table completed without error
cfg_err  out  1  retry count exhausted
err_idx  out  TBL_AW  index of the failing entry

Behaviour:
- Reset values: all outputs 0; state PWRUP; index 0; retry count 0.
- PWRUP:
  - Counts POWERUP_DLY cycles, then goes to FETCH.
  - busy = 1.
- FETCH:
  - Drives tbl_addr = idx.
  - Next cycle (FLATCH) latches tbl_data into internal entry registers.
- Entry dispatch after FLATCH:
  - dly_flag = 1: goes to DELAY.
  - dly_flag = 0: goes to ISSUE.
- DELAY:
  - Waits reg_data*DLY_UNIT cycles; reg_data = 0 gives zero wait (one cycle in DELAY).
  - No I2C activity; then advances.
- ISSUE:
  - i2c_exec = 1 for exactly one cycle, with i2c_rh_wl = 0.
  - i2c_addr and i2c_data are valid in that cycle and held stable until i2c_done.
  - Goes to WAIT.
- WAIT: on i2c_done:
  - ack_err = 0: advance.
  - ack_err = 1: retry count increments.
  - If the count reaches MAX_RETRY: go to FAIL, set err_idx = idx.
  - Otherwise go back to ISSUE on the next cycle.
- Advance:
  - Clears the retry count.
  - If idx == REG_NUM-1: go to DONE. Otherwise idx+1 and go to FETCH.
  - idx never wraps.
- DONE:
  - init_done = 1 from the cycle after the last i2c_done (or after the last DELAY ends).
- FAIL:
  - cfg_err = 1.
  - init_done stays 0.
- cfg_start (DONE/FAIL only):
  - Clears init_done, cfg_err and idx, then goes to FETCH; no power-up wait.
  - Ignored in every other state.
- Stray i2c_done outside WAIT is ignored.
- Reset mid-transfer: state returns to PWRUP immediately. The I2C master is reset by the same rst_n.
- ADDR_W = 8: tbl_data[17:16] holds the flags.
- Latency: one write entry takes 3 cycles plus the I2C transfer time (FETCH, FLATCH, ISSUE, then WAIT).

Optional Feature:
CFG_READBACK_EN
- Defined:
  - After a successful write of an entry with nv_flag = 0, issue a read of the same address (i2c_exec pulse, i2c_rh_wl = 1).
  - On done, compare i2c_rdata with reg_data.
  - A mismatch or NACK counts as one failed attempt; the retry restarts from the write.
  - Entries with nv_flag = 1 (soft reset, bank select, self-clearing registers) skip the readback.
- Undefined:
  - nv_flag is ignored, i2c_rh_wl is tied 0, and no read states exist.

Test Plan:
- POWERUP_DLY=16, REG_NUM=4, all writes acked -> first i2c_exec at cycle 16+3; four exec pulses with addresses and data matching the table; init_done rises 1 cycle after the 4th done; busy falls in the same cycle.
- Entry 2 = delay with reg_data=5 and DLY_UNIT=10 -> no i2c_exec for 50 cycles between entry 1 done and entry 3 exec.
- MAX_RETRY=3, NACK on entry 1 twice then ack -> three exec pulses for entry 1, sequence completes, cfg_err=0.
- NACK on entry 2 three times -> cfg_err=1, err_idx=2, init_done=0; cfg_start then gives a rerun from idx 0 with no power-up wait and all acked -> init_done=1, cfg_err=0.
- ADDR_W=16, entry {0,0,16'h3008,8'h82} -> i2c_addr=16'h3008, i2c_data=8'h82 during the exec cycle; cfg_start pulsed while busy -> ignored.
- With CFG_READBACK_EN: entry 0x11=0x00 with rdata 0x04 on the first readback and 0x00 on the second -> write, read, write, read, then advance; an entry with nv_flag=1 gives a write only.
